serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, multi-cycle adder/subtractor built from a chain of DIGIT-bit adder slices; it extends the single-bit full adder to WIDTH-bit operands.
- Processes DIGIT bits per clock, LSB first, and uses valid/ready handshakes on the input and output sides.
- Serves as the arithmetic unit where area matters more than latency, for example in accumulators and bootcamp datapath exercises.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT must equal 0; otherwise elaboration fails via a generate-time error.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry (add) or borrow (sub) in.
- sub  input  1  0 = a+b+carry_in; 1 = a-b-carry_in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- carry_out  output  1  carry out of the MSB; for sub, 1 = no borrow.
- busy  output  1  high in CALC or DONE.

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- N = WIDTH/DIGIT.
- States: IDLE, CALC, DONE.
- Reset: state=IDLE, sum=0, carry_out=0, out_valid=0, busy=0, digit counter=0, operand shift registers=0. in_ready=0 while rst is high.
- IDLE:
  - in_ready=1.
  - When in_valid is high at the edge: latch a into the A shift register and (sub ? ~b : b) into the B shift register, set the internal carry to carry_in ^ sub, clear the counter, go to CALC.
  - Inputs are ignored when in_valid is low.
- CALC:
  - Each cycle, add the low DIGIT bits of A and B plus the carry.
  - Shift the DIGIT result bits into the top of the sum register, shift A and B right by DIGIT, update the carry, increment the counter.
  - After the N-th digit (counter==N-1), register carry_out = final carry and go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; sum and carry_out are held stable.
  - When out_ready is high at the edge, go to IDLE, deassert out_valid, and keep sum/carry_out at their last values.
  - in_ready=0, so no new operands are accepted in the handshake cycle.
- Latency: accept at edge T; out_valid is first high after edge T+N. Minimum issue interval is N+2 cycles.
- Arithmetic is modulo 2^WIDTH. In sub mode, sum = a + ~b + ~carry_in.
- Boundary conditions:
  - in_valid held high through CALC/DONE is ignored.
  - out_ready high outside DONE has no effect.
  - rst high in any state aborts the operation on that edge and discards partial results.
  - DIGIT==WIDTH gives N=1 (single CALC cycle).

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined: adds output port overflow (1 bit), the signed overflow = (carry into MSB) XOR (carry out of MSB). It is captured at the final CALC digit, valid with out_valid, reset to 0, and held until the next result.
- Undefined: no overflow port and no related logic.

Decomposition:
- Shared header/package serial_adder_pkg holds:
  - state encodings: IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - the counter-width helper function (clog2).
- One sub-module, adder_digit: combinational DIGIT-bit ripple adder with parameter DIGIT and ports x, y, ci, s, co. It also exposes the carry into its top bit for the overflow feature.
- The FSM, shift registers and counter stay in serial_adder.

Test Plan:
- WIDTH=8, DIGIT=1, a=0x3C, b=0x0F, cin=0, sub=0 -> out_valid after exactly 8 CALC cycles, sum=0x4B, carry_out=0.
- a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, carry_out=1, overflow=0 (macro on). a=0x7F, b=0x01 -> sum=0x80, overflow=1.
- sub=1: a=0x10, b=0x01, cin=0 -> sum=0x0F, carry_out=1. a=0x00, b=0x01, cin=0 -> sum=0xFF, carry_out=0. a=0x05, b=0x02, cin=1 -> sum=0x02.
- Backpressure: out_ready low for 5 cycles in DONE with new in_valid asserted -> sum stable, in_ready=0, second operand not taken. out_ready high -> IDLE next cycle, then second operand accepted.
- Reset mid-op: rst high at the 3rd CALC cycle -> next cycle IDLE, sum=0, out_valid=0, in_ready=0 during rst, then 1.
- WIDTH=8, DIGIT=4: a=0xA5, b=0x5B -> result after 2 cycles, sum=0x00, carry_out=1. WIDTH=8, DIGIT=8 -> result after 1 cycle.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encodings and sizing helper for the serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_digit.sv
// adder_digit: combinational DIGIT-bit ripple adder exposing the carry into its top bit
module adder_digit
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             ct
);

  logic [DIGIT:0] c;

  // ripple the carry through each bit of the digit
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[DIGIT];
  assign ct = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor, LSB first; SERIAL_ADDER_OVF_EN adds a signed overflow output
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (clog2(N) > 0) ? clog2(N) : 1;

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic [CW-1:0]    cnt_q;
  logic             c_q, co_q, ov_q, out_valid_q, busy_q;
  logic [DIGIT-1:0] s;
  logic             co, ct;
  logic             last;

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .x (a_q[DIGIT-1:0]),
    .y (b_q[DIGIT-1:0]),
    .ci(c_q),
    .s (s),
    .co(co),
`ifdef SERIAL_ADDER_OVF_EN
    .ct(ct)
`else
    .ct()
`endif
  );

  if (N == 1) begin : g_one
    assign sum_d = s;
  end else begin : g_many
    assign sum_d = {s, sum_q[WIDTH-1:DIGIT]};
  end

  assign last      = cnt_q == CW'(N - 1);
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign carry_out = co_q;

  // control FSM, operand shift registers, digit counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      co_q        <= 1'b0;
      ov_q        <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          c_q     <= carry_in ^ sub;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= CALC;
        end
        CALC: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          sum_q <= sum_d;
          c_q   <= co;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            co_q        <= co;
            ov_q        <= ct ^ co;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  assign overflow = ov_q;
`else
  logic unused_ov;
  assign unused_ov = ov_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at DIGIT = 1, 4 and 8 (WIDTH = 8)
module tb_serial_adder;

  logic             clk = 0;
  logic             rst = 1;
  logic [7:0]       a = '0, b = '0;
  logic             carry_in = 0, sub = 0, out_ready = 0;
  logic [2:0]       iv_w = '0, ir_w, vo_w, co_w, bz_w;
  logic [2:0][7:0]  sum_w;
`ifdef SERIAL_ADDER_OVF_EN
  logic [2:0]       of_w;
`endif
  logic [9:0]       q[$];
  int               n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv_w[0]), .in_ready(ir_w[0]), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(vo_w[0]), .out_ready(out_ready),
    .sum(sum_w[0]), .carry_out(co_w[0]), .busy(bz_w[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .overflow(of_w[0])
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv_w[1]), .in_ready(ir_w[1]), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(vo_w[1]), .out_ready(out_ready),
    .sum(sum_w[1]), .carry_out(co_w[1]), .busy(bz_w[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .overflow(of_w[1])
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(iv_w[2]), .in_ready(ir_w[2]), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(vo_w[2]), .out_ready(out_ready),
    .sum(sum_w[2]), .carry_out(co_w[2]), .busy(bz_w[2])
`ifdef SERIAL_ADDER_OVF_EN
    , .overflow(of_w[2])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // {overflow, carry_out, sum[7:0]} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic ci, input logic sb);
    logic [7:0] bb;
    logic [8:0] r;
    logic       ov;
    bb = sb ? ~bv : bv;
    r  = {1'b0, av} + {1'b0, bb} + {8'd0, sb ? ~ci : ci};
    ov = (av[7] == bb[7]) && (r[7] != av[7]);
    return {ov, r};
  endfunction

  task automatic issue(input int k, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic sb);
    int t;
    q.push_back(model(av, bv, ci, sb));
    @(negedge clk);
    a = av; b = bv; carry_in = ci; sub = sb;
    iv_w[k] = 1'b1;
    t = 0;
    while (!ir_w[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept", {31'd0, ir_w[k]}, 1);
    @(posedge clk);
    #1 iv_w[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, input int n);
    int         lat;
    logic [9:0] e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!vo_w[k] && lat < 100);
    check("latency", lat, n + 1);
    e = (q.size() > 0) ? q.pop_front() : 10'h3ff;
    check("sum", {24'd0, sum_w[k]}, {24'd0, e[7:0]});
    check("carry_out", {31'd0, co_w[k]}, {31'd0, e[8]});
`ifdef SERIAL_ADDER_OVF_EN
    check("overflow", {31'd0, of_w[k]}, {31'd0, e[9]});
`endif
  endtask

  task automatic release_out(input int k);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_clr", {31'd0, vo_w[k]}, 0);
    check("busy_clr", {31'd0, bz_w[k]}, 0);
    check("in_ready_idle", {31'd0, ir_w[k]}, 1);
  endtask

  task automatic op(input int k, input int n, input logic [7:0] av, input logic [7:0] bv,
                    input logic ci, input logic sb);
    issue(k, av, bv, ci, sb);
    wait_valid(k, n);
    release_out(k);
  endtask

  initial begin
    logic [7:0] hold_sum;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {29'd0, ir_w}, 0);
    check("rst_out_valid", {29'd0, vo_w}, 0);
    check("rst_busy", {29'd0, bz_w}, 0);
    check("rst_sum", {8'd0, sum_w}, 0);
    check("rst_carry_out", {29'd0, co_w}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_overflow", {29'd0, of_w}, 0);
`endif
    rst = 0;
    #1 check("in_ready_after_rst", {29'd0, ir_w}, 3'b111);

    op(0, 8, 8'h3C, 8'h0F, 0, 0);
    op(0, 8, 8'hFF, 8'h01, 0, 0);
    op(0, 8, 8'h7F, 8'h01, 0, 0);
    op(0, 8, 8'h10, 8'h01, 0, 1);
    op(0, 8, 8'h00, 8'h01, 0, 1);
    op(0, 8, 8'h05, 8'h02, 1, 1);
    op(0, 8, 8'h80, 8'h01, 0, 1);
    op(0, 8, 8'hFE, 8'h03, 1, 0);

    // backpressure: result held while a second operand waits
    issue(0, 8'h11, 8'h22, 0, 0);
    wait_valid(0, 8);
    hold_sum = sum_w[0];
    @(negedge clk);
    a = 8'h33; b = 8'h44; carry_in = 0; sub = 0;
    iv_w[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, ir_w[0]}, 0);
      check("bp_out_valid", {31'd0, vo_w[0]}, 1);
      check("bp_sum_stable", {24'd0, sum_w[0]}, {24'd0, hold_sum});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_valid", {31'd0, vo_w[0]}, 0);
    check("bp_idle_ready", {31'd0, ir_w[0]}, 1);
    check("bp_sum_kept", {24'd0, sum_w[0]}, {24'd0, hold_sum});
    q.push_back(model(8'h33, 8'h44, 0, 0));
    @(posedge clk);
    #1 iv_w[0] = 1'b0;
    wait_valid(0, 8);
    release_out(0);

    // out_ready asserted while idle does nothing
    @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check("idle_oready_valid", {31'd0, vo_w[0]}, 0);
    check("idle_oready_busy", {31'd0, bz_w[0]}, 0);

    // reset during the third CALC cycle
    issue(0, 8'hAA, 8'h55, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready_rst", {31'd0, ir_w[0]}, 0);
    @(posedge clk);
    #1;
    void'(q.pop_back());
    check("abort_sum", {24'd0, sum_w[0]}, 0);
    check("abort_out_valid", {31'd0, vo_w[0]}, 0);
    check("abort_busy", {31'd0, bz_w[0]}, 0);
    check("abort_in_ready_hold", {31'd0, ir_w[0]}, 0);
    rst = 1'b0;
    #1 check("abort_in_ready_free", {31'd0, ir_w[0]}, 1);
    op(0, 8, 8'h12, 8'h34, 1, 0);

    for (int i = 0; i < 6; i++)
      op(0, 8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    op(1, 2, 8'hA5, 8'h5B, 0, 0);
    op(1, 2, 8'h7F, 8'h01, 0, 0);
    op(1, 2, 8'h00, 8'h01, 0, 1);
    op(2, 1, 8'hA5, 8'h5B, 0, 0);
    op(2, 1, 8'h05, 8'h02, 1, 1);
    op(2, 1, 8'h7F, 8'h01, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
